// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared types and helpers for the shared-GCD arbitration slice.
//   gcd_arb_state_t : arbiter FSM states
//   GCD_W           : datapath width of the gcd_ci engine
//   idx_w()         : width of a requester index for n requesters
// -----------------------------------------------------------------------------
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } gcd_arb_state_t;

  localparam int GCD_W = 32;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Returns the first set request found when
// searching upward from the pointer, wrapping past NUM_REQ-1 back to 0.
//   req_i     : request vector
//   ptr_i     : search start index (highest priority this round)
//   grant_o   : selected index (0 when no request)
//   any_req_o : at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_req_o
);

  int               pos;
  logic [IDX_W-1:0] sel;

  // Walk offsets from the farthest to the nearest so the closest hit to the
  // pointer is the last assignment and therefore wins.
  always_comb begin
    grant_o   = '0;
    any_req_o = |req_i;
    pos       = 0;
    sel       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = int'(ptr_i) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      sel = IDX_W'(pos);
      if (req_i[sel]) grant_o = sel;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
// Shares one gcd_ci Euclid engine among NUM_REQ requesters with round-robin
// arbitration. Zero operands are answered locally (the engine never finishes
// on them) and every engine run is bounded by TIMEOUT_CYCLES.
//   csi_clk, rsi_reset       : clock, synchronous active-high reset
//   req_valid/req_a/req_b    : per-requester request and packed operands
//   rsp_valid/rsp_data/rsp_err : one-cycle response to the served requester
//   eng_clk_en/eng_start/eng_a/eng_b : drive the engine
//   eng_result/eng_done      : engine result and sticky done
//   busy                     : FSM not in IDLE
// DATA_W must equal the engine width GCD_W.
// -----------------------------------------------------------------------------
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = GCD_W,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                        csi_clk,
  input  logic                        rsi_reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        eng_clk_en,
  output logic                        eng_start,
  output logic [DATA_W-1:0]           eng_a,
  output logic [DATA_W-1:0]           eng_b,
  input  logic [DATA_W-1:0]           eng_result,
  input  logic                        eng_done,
  output logic                        busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  gcd_arb_state_t     state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic [DATA_W-1:0]  a_arr [NUM_REQ];
  logic [DATA_W-1:0]  b_arr [NUM_REQ];
  logic [IDX_W-1:0]   arb_grant;
  logic               arb_any;
  logic [DATA_W-1:0]  cand_a, cand_b;
  logic               cand_zero;
  logic               timeout_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g] = req_b[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (arb_any)
  );

  assign cand_a      = a_arr[arb_grant];
  assign cand_b      = b_arr[arb_grant];
  assign cand_zero   = (cand_a == '0) || (cand_b == '0);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---- state register (control only is reset) ----
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operand/result holding registers; every output they reach is gated by
  // state, so they need no reset.
  always_ff @(posedge csi_clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    result_q <= result_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = cand_zero ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_done || timeout_hit) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and bookkeeping next values.
  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_grant;
          a_d      = cand_a;
          b_d      = cand_b;
          // gcd(x,0)=x and gcd(0,0)=0; overwritten later on the engine path.
          result_d = cand_a | cand_b;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // done takes precedence over a timeout landing in the same cycle.
        if (eng_done) begin
          result_d = eng_result;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          result_d = '0;
        end
      end
      RESP: begin
        ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        cnt_d = '0;
        err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    rsp_valid  = '0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    eng_clk_en = 1'b0;
    eng_start  = 1'b0;
    eng_a      = '0;
    eng_b      = '0;
    busy       = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        eng_clk_en = 1'b1;
        eng_start  = 1'b1;
        eng_a      = a_q;
        eng_b      = b_q;
      end
      // eng_done is only sampled in WAIT, so a stale done seen during ISSUE
      // has no effect.
      WAIT: eng_clk_en = 1'b1;
      // DRAIN keeps clk_en low for one cycle, clearing the sticky done.
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_data           = result_q;
        rsp_err            = err_q;
      end
      default: ;
    endcase
  end

endmodule
